score_arbiter: RTL and testbench

- Sequences score additions into the score accumulator, whose BCD adder must not start a new sum while the previous one is still in flight.
- Collects one-cycle score events from N requesters (asteroid sizes, UFO, etc.) and queues them per requester.
- Grants pending events round-robin and drives the accumulator's sum input with one requester's BCD point value for exactly one cycle, then holds sum at zero for a guard interval.

---
 rtl/score_arbiter.sv | 172 +++++++++++++++++
 tb/tb_score_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_arbiter.sv
// Round-robin arbiter that issues queued per-requester BCD score values to a
// shared accumulator, one pulse at a time with a guard gap. Option: SCORE_ARB_DOUBLE_EN.
module score_arbiter #(
    parameter int N      = 4,
    parameter int DIGITS = 4,
    parameter int GAP    = 2,
    parameter int PEND_W = 4
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [N-1:0]          req,
    input  logic [N*DIGITS*4-1:0] pts,
`ifdef SCORE_ARB_DOUBLE_EN
    input  logic                  double_pts,
`endif
    input  logic                  clr_drop,
    output logic [DIGITS*4-1:0]   sum,
    output logic                  busy,
    output logic                  drop,
    output logic [N-1:0]          grant
);

    localparam int SW    = DIGITS * 4;
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [N-1:0]      ONE      = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, WAIT, REPEAT} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [PTR_W-1:0]  rr, win;
    logic              any_pend;
    logic [N-1:0]      take;
    logic [PEND_W-1:0] pend      [N];
    logic [PEND_W-1:0] pend_next [N];
    logic              drop_set, drop_next;
    logic [SW-1:0]     sum_next;
    logic [N-1:0]      grant_next;
`ifdef SCORE_ARB_DOUBLE_EN
    logic              second, second_next;
    logic [SW-1:0]     held_sum;
    logic [N-1:0]      held_grant;
`endif

    // Saturating pending-count update; an increment at full scale is dropped.
    function automatic logic [PEND_W-1:0] pend_step(input logic [PEND_W-1:0] p,
                                                     input logic inc, input logic dec);
        if (inc && !dec) return (p == PEND_MAX) ? p : p + 1'b1;
        if (dec && !inc) return p - 1'b1;
        return p;
    endfunction

    always_comb begin
        int idx;
        idx      = 0;
        win      = rr;
        any_pend = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(rr) + k) % N;
            if (!any_pend && pend[idx] != '0) begin
                any_pend = 1'b1;
                win      = PTR_W'(idx);
            end
        end
    end

    assign take = (state == IDLE && any_pend) ? (ONE << win) : '0;
    assign busy = (state != IDLE) || any_pend;

    always_comb begin
        drop_set = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend_next[i] = pend_step(pend[i], req[i], take[i]);
            if (req[i] && !take[i] && pend[i] == PEND_MAX) drop_set = 1'b1;
        end
        drop_next = drop_set | (drop & ~clr_drop);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
            cnt   <= '0;
            rr    <= PTR_W'(N - 1);
            sum   <= '0;
            grant <= '0;
            drop  <= 1'b0;
            for (int i = 0; i < N; i++) pend[i] <= '0;
`ifdef SCORE_ARB_DOUBLE_EN
            second <= 1'b0;
`endif
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            sum   <= sum_next;
            grant <= grant_next;
            drop  <= drop_next;
            for (int i = 0; i < N; i++) pend[i] <= pend_next[i];
            if (state == IDLE && any_pend) rr <= win;
`ifdef SCORE_ARB_DOUBLE_EN
            second <= second_next;
`endif
        end
    end

`ifdef SCORE_ARB_DOUBLE_EN
    // Value and grant of the first pulse, replayed unchanged for the second.
    always_ff @(posedge clk) begin
        if (state == IDLE && any_pend) begin
            held_sum   <= sum_next;
            held_grant <= take;
        end
    end
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
`ifdef SCORE_ARB_DOUBLE_EN
        second_next = second;
`endif
        case (state)
            IDLE: begin
                if (any_pend) begin
                    state_next = WAIT;
                    cnt_next   = CNT_W'(GAP);
`ifdef SCORE_ARB_DOUBLE_EN
                    second_next = double_pts;
`endif
                end
            end
            WAIT: begin
                if (cnt == '0) begin
`ifdef SCORE_ARB_DOUBLE_EN
                    if (second) begin
                        state_next  = REPEAT;
                        second_next = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
`else
                    state_next = IDLE;
`endif
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            REPEAT: begin
                state_next = WAIT;
                cnt_next   = CNT_W'(GAP);
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sum_next   = '0;
        grant_next = '0;
        if (state == IDLE && any_pend) begin
            sum_next   = pts[int'(win) * SW +: SW];
            grant_next = take;
        end
`ifdef SCORE_ARB_DOUBLE_EN
        else if (state == REPEAT) begin
            sum_next   = held_sum;
            grant_next = held_grant;
        end
`endif
    end

endmodule

// File: tb/tb_score_arbiter.sv
// Directed bench for score_arbiter; covers SCORE_ARB_DOUBLE_EN when defined.
module tb_score_arbiter;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [3:0]  req = '0;
    logic [63:0] pts = '0;
    logic        clr_drop = 1'b0;
`ifdef SCORE_ARB_DOUBLE_EN
    logic        double_pts = 1'b0;
`endif
    logic [15:0] sum;
    logic        busy, drop;
    logic [3:0]  grant;

    score_arbiter #(.N(4), .DIGITS(4), .GAP(2), .PEND_W(4)) dut (
        .clk(clk), .resetN(resetN), .req(req), .pts(pts),
`ifdef SCORE_ARB_DOUBLE_EN
        .double_pts(double_pts),
`endif
        .clr_drop(clr_drop), .sum(sum), .busy(busy), .drop(drop), .grant(grant)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0, cyc = 0, score = 0, proto_err = 0;
    bit prev_nz = 1'b0;
    logic [3:0]  log_g[$];
    logic [15:0] log_s[$];
    int          log_c[$];

    function automatic int bcd2int(input logic [15:0] v);
        int r;
        r = 0;
        for (int k = 3; k >= 0; k--) r = r * 10 + int'(v[k*4 +: 4]);
        return r;
    endfunction

    always @(posedge clk) cyc++;

    // Pulse recorder: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (grant != 4'b0) begin
            log_g.push_back(grant);
            log_s.push_back(sum);
            log_c.push_back(cyc);
            score += bcd2int(sum);
        end
        if (sum != 16'h0 && (prev_nz || grant == 4'b0)) proto_err++;
        prev_nz = (sum != 16'h0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_g.delete(); log_s.delete(); log_c.delete();
        score = 0; proto_err = 0;
    endtask

    task automatic apply_reset();
        resetN = 1'b0; req = '0; pts = '0; clr_drop = 1'b0;
        tick(); tick();
        resetN = 1'b1;
        clear_log();
    endtask

    task automatic test_reset();
        req = '0;
        resetN = 1'b0;
        #1;
        n_vec++; if (sum !== 16'h0) begin n_err++; $display("FAIL reset_sum: got %h expected 0000", sum); end
        n_vec++; if (grant !== 4'h0) begin n_err++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        n_vec++; if (drop !== 1'b0) begin n_err++; $display("FAIL reset_drop: got %b expected 0", drop); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        apply_reset();
        pts[31:16] = 16'h0020; req = 4'b0010;
        tick(); req = '0;
        n_vec++; if (sum !== 16'h0) begin n_err++; $display("FAIL single_early: got %h expected 0000", sum); end
        tick();
        n_vec++; if (sum !== 16'h0020) begin n_err++; $display("FAIL single_sum: got %h expected 0020", sum); end
        n_vec++; if (grant !== 4'b0010) begin n_err++; $display("FAIL single_grant: got %b expected 0010", grant); end
        tick();
        n_vec++; if (sum !== 16'h0 || grant !== 4'h0) begin n_err++; $display("FAIL single_one_cycle: got %h/%b expected 0000/0000", sum, grant); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_w1: got %b expected 1", busy); end
        tick();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_w3: got %b expected 1", busy); end
        tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_fall: got %b expected 0", busy); end
        n_vec++; if (score !== 20) begin n_err++; $display("FAIL single_score: got %0d expected 20", score); end
    endtask

    task automatic test_simultaneous();
        logic [15:0] exp_s[4];
        exp_s = '{16'h0010, 16'h0020, 16'h0050, 16'h0100};
        apply_reset();
        pts = {16'h0100, 16'h0050, 16'h0020, 16'h0010}; req = 4'hF;
        tick(); req = '0;
        repeat (20) tick();
        n_vec++;
        if (log_g.size() !== 4) begin
            n_err++; $display("FAIL simul_count: got %0d expected 4", log_g.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++; if (log_g[i] !== 4'(1 << i)) begin n_err++; $display("FAIL simul_grant%0d: got %b expected %b", i, log_g[i], 4'(1 << i)); end
                n_vec++; if (log_s[i] !== exp_s[i]) begin n_err++; $display("FAIL simul_sum%0d: got %h expected %h", i, log_s[i], exp_s[i]); end
                if (i > 0) begin
                    n_vec++; if (log_c[i] - log_c[i-1] !== 4) begin n_err++; $display("FAIL simul_gap%0d: got %0d expected 4", i, log_c[i] - log_c[i-1]); end
                end
            end
        end
        n_vec++; if (score !== 180) begin n_err++; $display("FAIL simul_score: got %0d expected 180", score); end
        n_vec++; if (proto_err !== 0) begin n_err++; $display("FAIL simul_protocol: got %0d expected 0", proto_err); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL simul_idle: got %b expected 0", busy); end
    endtask

    task automatic test_fairness();
        int n2;
        logic [3:0] exp_g[4];
        exp_g = '{4'b0001, 4'b0100, 4'b0001, 4'b0001};
        apply_reset();
        pts = {16'h0000, 16'h0002, 16'h0000, 16'h0001};
        for (int i = 0; i < 20; i++) begin
            req = (i == 0) ? 4'b0101 : 4'b0001;
            tick();
        end
        req = '0;
        n_vec++;
        if (log_g.size() < 4) begin
            n_err++; $display("FAIL rr_count: got %0d expected >=4", log_g.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++; if (log_g[i] !== exp_g[i]) begin n_err++; $display("FAIL rr_order%0d: got %b expected %b", i, log_g[i], exp_g[i]); end
            end
        end
        n2 = 0;
        foreach (log_g[i]) if (log_g[i] == 4'b0100) n2++;
        n_vec++; if (n2 !== 1) begin n_err++; $display("FAIL rr_req2_once: got %0d expected 1", n2); end
    endtask

    task automatic test_saturation();
        int k;
        apply_reset();
        pts[63:48] = 16'h0001;
        for (int i = 0; i < 24; i++) begin
            req = 4'b1000;
            clr_drop = (i == 22);
            tick();
            if (i == 19) begin
                n_vec++; if (drop !== 1'b0) begin n_err++; $display("FAIL sat_no_drop_yet: got %b expected 0", drop); end
            end
            if (i == 22) begin
                n_vec++; if (drop !== 1'b1) begin n_err++; $display("FAIL sat_clr_vs_drop: got %b expected 1", drop); end
            end
        end
        req = '0; clr_drop = 1'b1;
        tick();
        clr_drop = 1'b0;
        n_vec++; if (drop !== 1'b0) begin n_err++; $display("FAIL sat_clr: got %b expected 0", drop); end
        k = 0;
        while (busy && k < 200) begin tick(); k++; end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL sat_drain_timeout: got busy %b expected 0", busy); end
        n_vec++; if (log_g.size() !== 21) begin n_err++; $display("FAIL sat_issued: got %0d expected 21", log_g.size()); end
        n_vec++; if (score !== 21) begin n_err++; $display("FAIL sat_score: got %0d expected 21", score); end
        n_vec++; if (proto_err !== 0) begin n_err++; $display("FAIL sat_protocol: got %0d expected 0", proto_err); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        pts[15:0] = 16'h0007; req = 4'b0001;
        repeat (4) tick();
        req = '0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_pre_busy: got %b expected 1", busy); end
        n_vec++; if (log_g.size() !== 1) begin n_err++; $display("FAIL rmid_pre_count: got %0d expected 1", log_g.size()); end
        #2 resetN = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        n_vec++; if (sum !== 16'h0 || grant !== 4'h0) begin n_err++; $display("FAIL rmid_out: got %h/%b expected 0000/0000", sum, grant); end
        tick();
        resetN = 1'b1;
        clear_log();
        repeat (20) tick();
        n_vec++; if (log_g.size() !== 0) begin n_err++; $display("FAIL rmid_no_pulse: got %0d expected 0", log_g.size()); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_idle: got %b expected 0", busy); end
    endtask

    task automatic test_passthrough();
        apply_reset();
        pts = {16'h0000, 16'h00FA, 16'h0000, 16'h0000}; req = 4'b1100;
        tick(); req = '0;
        repeat (12) tick();
        n_vec++;
        if (log_g.size() !== 2) begin
            n_err++; $display("FAIL pass_count: got %0d expected 2", log_g.size());
        end else begin
            n_vec++; if (log_g[0] !== 4'b0100 || log_s[0] !== 16'h00FA) begin n_err++; $display("FAIL pass_raw: got %b/%h expected 0100/00fa", log_g[0], log_s[0]); end
            n_vec++; if (log_g[1] !== 4'b1000 || log_s[1] !== 16'h0000) begin n_err++; $display("FAIL pass_zero: got %b/%h expected 1000/0000", log_g[1], log_s[1]); end
            n_vec++; if (log_c[1] - log_c[0] !== 4) begin n_err++; $display("FAIL pass_gap: got %0d expected 4", log_c[1] - log_c[0]); end
        end
    endtask

`ifdef SCORE_ARB_DOUBLE_EN
    task automatic test_double();
        apply_reset();
        pts[15:0] = 16'h0500; req = 4'b0001; double_pts = 1'b1;
        tick(); req = '0;
        tick(); double_pts = 1'b0;
        repeat (14) tick();
        n_vec++;
        if (log_g.size() !== 2) begin
            n_err++; $display("FAIL dbl_count: got %0d expected 2", log_g.size());
        end else begin
            n_vec++; if (log_g[1] !== 4'b0001 || log_s[1] !== 16'h0500) begin n_err++; $display("FAIL dbl_second: got %b/%h expected 0001/0500", log_g[1], log_s[1]); end
            n_vec++; if (log_c[1] - log_c[0] !== 4) begin n_err++; $display("FAIL dbl_gap: got %0d expected 4", log_c[1] - log_c[0]); end
        end
        n_vec++; if (score !== 1000) begin n_err++; $display("FAIL dbl_score: got %0d expected 1000", score); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL dbl_pend_zero: got %b expected 0", busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_saturation();
        test_reset_mid();
        test_passthrough();
`ifdef SCORE_ARB_DOUBLE_EN
        test_double();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
